// File: rtl/ofifo_drain_pkg.sv
// Shared types and default sizing for the OFIFO drain / psum accumulate block.
package ofifo_drain_pkg;

  localparam int COL      = 8;
  localparam int PSUM_BW  = 16;
  localparam int NUM_OUT  = 16;
  localparam int NUM_PASS = 9;
  localparam int ADDR_W   = 11;

  localparam int ROW_W = COL * PSUM_BW;
  localparam int TOTAL = NUM_PASS * NUM_OUT;

  // Counter width, kept at least 1 bit so a degenerate count of 1 still elaborates
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PASS_W = cnt_w(NUM_PASS);
  localparam int OUT_W  = cnt_w(NUM_OUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    ACCUM = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Which counter runs fastest: o for the linear drain, p for per-row accumulation
  typedef enum logic {
    ORD_O_INNER = 1'b0,
    ORD_P_INNER = 1'b1
  } order_t;

endpackage

// File: rtl/psum_addr_gen.sv
// Pass/output counter pair with selectable nesting; produces addr = p*num_out + o.
module psum_addr_gen
  import ofifo_drain_pkg::*;
#(
  parameter int num_out  = NUM_OUT,
  parameter int num_pass = NUM_PASS,
  parameter int addr_w   = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  order_t            order,
  output logic              inner_first,
  output logic              inner_last,
  output logic              last,
  output logic [addr_w-1:0] addr
);

  localparam int PW = cnt_w(num_pass);
  localparam int OW = cnt_w(num_out);
  localparam logic [PW-1:0]     P_MAX = PW'(num_pass - 1);
  localparam logic [OW-1:0]     O_MAX = OW'(num_out - 1);
  localparam logic [addr_w-1:0] O_SPAN = addr_w'(num_out);

  logic [PW-1:0] p;
  logic [OW-1:0] o;
  logic          p_end;
  logic          o_end;

  assign p_end       = (p == P_MAX);
  assign o_end       = (o == O_MAX);
  assign last        = p_end && o_end;
  assign inner_last  = (order == ORD_O_INNER) ? o_end : p_end;
  assign inner_first = (order == ORD_O_INNER) ? (o == '0) : (p == '0);
  assign addr        = addr_w'(p) * O_SPAN + addr_w'(o);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
      o <= '0;
    end else if (clr) begin
      p <= '0;
      o <= '0;
    end else if (step) begin
      if (order == ORD_O_INNER) begin
        if (o_end) begin
          o <= '0;
          p <= p_end ? '0 : p + 1'b1;
        end else begin
          o <= o + 1'b1;
        end
      end else begin
        if (p_end) begin
          p <= '0;
          o <= o_end ? '0 : o + 1'b1;
        end else begin
          p <= p + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ofifo_drain.sv
// Drains OFIFO rows into psum SRAM, then replays them per output row into the corelet SFP.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col      = COL,
  parameter int psum_bw  = PSUM_BW,
  parameter int num_out  = NUM_OUT,
  parameter int num_pass = NUM_PASS,
  parameter int addr_w   = ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     pmem_wr,
  output logic                     pmem_rd,
  output logic [addr_w-1:0]        pmem_addr,
  output logic [col*psum_bw-1:0]   pmem_din,
  output logic                     acc,
  output logic                     sfp_clr,
  output logic                     sfp_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = col * psum_bw;

  state_t            state;
  order_t            order;
  logic              pop;
  logic              rd_now;
  logic              gap;
  logic              cnt_step;
  logic              cnt_clr;
  logic              inner_first;
  logic              inner_last;
  logic              last;
  logic [addr_w-1:0] addr;
  logic              wr_vld_p1;
  logic [RW-1:0]     din_p1;
  logic              sfp_vld_p0;
  logic              sfp_vld_p1;

  assign order = (state == ACCUM) ? ORD_P_INNER : ORD_O_INNER;

  // Stop popping once the final row is already waiting in the write stage
  assign pop      = (state == DRAIN) && ofifo_valid && !(wr_vld_p1 && last);
  assign rd_now   = (state == ACCUM) && !gap;
  assign cnt_step = ((state == DRAIN) && wr_vld_p1) || rd_now;
  assign cnt_clr  = (state == IDLE);

  psum_addr_gen #(
    .num_out  (num_out),
    .num_pass (num_pass),
    .addr_w   (addr_w)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clr),
    .step        (cnt_step),
    .order       (order),
    .inner_first (inner_first),
    .inner_last  (inner_last),
    .last        (last),
    .addr        (addr)
  );

  assign ofifo_rd  = pop;
  assign pmem_wr   = wr_vld_p1;
  assign pmem_rd   = rd_now;
  assign acc       = rd_now;
  assign sfp_clr   = rd_now && inner_first;
  assign pmem_addr = (wr_vld_p1 || rd_now) ? addr : '0;
  assign pmem_din  = din_p1;
  assign sfp_valid = sfp_vld_p1;
  assign busy      = (state == DRAIN) || (state == ACCUM) || (state == FLUSH);
  assign done      = (state == DONE);

  // p0 -> p1: popped row becomes the pending SRAM write word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_p1 <= '0;
    end else if (pop) begin
      din_p1 <= ofifo_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gap        <= 1'b0;
      wr_vld_p1  <= 1'b0;
      sfp_vld_p0 <= 1'b0;
      sfp_vld_p1 <= 1'b0;
    end else begin
      wr_vld_p1  <= pop;
      // p0 -> p1: SRAM read latency plus the corelet acc register
      sfp_vld_p0 <= rd_now && inner_last;
      sfp_vld_p1 <= sfp_vld_p0;
      case (state)
        IDLE: begin
          gap <= 1'b0;
          if (start) state <= DRAIN;
        end
        DRAIN: begin
          gap <= 1'b0;
          if (wr_vld_p1 && last) state <= ACCUM;
        end
        ACCUM: begin
          if (rd_now) begin
            if (last)            state <= FLUSH;
            else if (inner_last) gap   <= 1'b1;
          end else begin
            gap <= 1'b0;
          end
        end
        FLUSH: begin
          if (sfp_vld_p1) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain with an SRAM model and a lane-0 SFP accumulator model.
module tb_ofifo_drain;
  import ofifo_drain_pkg::*;

  localparam int BW  = 16;
  localparam int NO  = 16;
  localparam int NP  = 9;
  localparam int AW  = 11;
  localparam int RW  = 8 * BW;
  localparam int TOT = NO * NP;

  logic          clk;
  logic          reset;
  logic          start;
  logic          ofifo_valid;
  logic [RW-1:0] ofifo_out;
  logic          ofifo_rd;
  logic          pmem_wr;
  logic          pmem_rd;
  logic [AW-1:0] pmem_addr;
  logic [RW-1:0] pmem_din;
  logic          acc;
  logic          sfp_clr;
  logic          sfp_valid;
  logic          busy;
  logic          done;

  ofifo_drain #(
    .col(8), .psum_bw(BW), .num_out(NO), .num_pass(NP), .addr_w(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .pmem_wr(pmem_wr),
    .pmem_rd(pmem_rd), .pmem_addr(pmem_addr), .pmem_din(pmem_din),
    .acc(acc), .sfp_clr(sfp_clr), .sfp_valid(sfp_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt;
  int bad_cnt;

  logic [RW-1:0] mem [TOT];
  int sums[$];
  int wr_cnt, wr_addr_bad, wr_data_bad, first_wr_addr;
  int rd_cnt, rd_addr_bad, rd_time_bad, clr_bad;
  int sfp_cnt, sfp_time_bad, follow_bad, viol;
  int done_cnt, done_cyc, busy_bad;

  // Row i = pass*NO + out; lane l carries the row value plus l<<12 so lanes are distinguishable
  function automatic logic [RW-1:0] row_val(input int i, input int dmode);
    logic [RW-1:0] r;
    int v;
    v = (dmode == 0) ? i : (i / NO + 1);
    for (int l = 0; l < 8; l++) r[l*BW +: BW] = 16'(v + l * 4096);
    return r;
  endfunction

  // vmode 0: ofifo_valid always high; 1: pattern 1,0,0,1. poke_cyc: extra start pulse cycle (-1 none)
  task automatic run(input int vmode, input int dmode, input int poke_cyc);
    int idx, s, q_addr, rd_t0, last_rd_cyc, k;
    logic q_vld, q_clr, prev_busy, vbit;
    idx = 0; s = 0; q_vld = 0; q_clr = 0; q_addr = 0; prev_busy = 0;
    rd_t0 = 0; last_rd_cyc = -100;
    wr_cnt = 0; wr_addr_bad = 0; wr_data_bad = 0; first_wr_addr = -1;
    rd_cnt = 0; rd_addr_bad = 0; rd_time_bad = 0; clr_bad = 0;
    sfp_cnt = 0; sfp_time_bad = 0; follow_bad = 0; viol = 0;
    done_cnt = 0; done_cyc = -1; busy_bad = 0;
    sums.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == poke_cyc);
      vbit = (vmode == 0) || ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      ofifo_valid = (c >= 1) && (idx < TOT) && vbit;
      ofifo_out = (idx < TOT) ? row_val(idx, dmode) : '0;
      #1;
      if (idx < TOT && ofifo_rd !== ofifo_valid) follow_bad++;
      if (ofifo_rd && (idx >= TOT || !busy)) viol++;
      if (pmem_wr && pmem_rd) viol++;
      if (!pmem_wr && !pmem_rd && pmem_addr != '0) viol++;
      if (acc !== pmem_rd) viol++;
      if (pmem_wr) begin
        if (first_wr_addr < 0) first_wr_addr = int'(pmem_addr);
        if (int'(pmem_addr) != wr_cnt) wr_addr_bad++;
        if (pmem_din !== row_val(wr_cnt, dmode)) wr_data_bad++;
        if (int'(pmem_addr) < TOT) mem[int'(pmem_addr)] = pmem_din;
        wr_cnt++;
      end
      if (q_vld) s = (q_clr ? 0 : s) + ((q_addr < TOT) ? int'(mem[q_addr][BW-1:0]) : 0);
      if (pmem_rd) begin
        k = rd_cnt;
        if (k == 0) rd_t0 = c;
        if (c != rd_t0 + (k / NP) * (NP + 1) + (k % NP)) rd_time_bad++;
        if (int'(pmem_addr) != (k % NP) * NO + (k / NP)) rd_addr_bad++;
        if (sfp_clr !== ((k % NP) == 0)) clr_bad++;
        if ((k % NP) == NP - 1) last_rd_cyc = c;
        rd_cnt++;
      end else if (sfp_clr) begin
        clr_bad++;
      end
      q_vld = pmem_rd; q_clr = sfp_clr; q_addr = int'(pmem_addr);
      if (sfp_valid) begin
        sfp_cnt++;
        if (c - last_rd_cyc != 2) sfp_time_bad++;
        sums.push_back(s);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (busy || !prev_busy) busy_bad++;
      end
      prev_busy = busy;
      if (ofifo_rd) idx++;
      if (done_cyc >= 0 && c >= done_cyc + 20) break;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0; ofifo_out = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({ofifo_rd, pmem_wr, pmem_rd, acc, sfp_clr, sfp_valid, busy, done} !== 8'b0) begin
      bad_cnt++;
      $display("FAIL reset_ctrl got=%b want=00000000",
               {ofifo_rd, pmem_wr, pmem_rd, acc, sfp_clr, sfp_valid, busy, done});
    end
    total_cnt++;
    if (pmem_addr !== '0) begin bad_cnt++; $display("FAIL reset_addr got=%0d want=0", pmem_addr); end
    total_cnt++;
    if (pmem_din !== '0) begin bad_cnt++; $display("FAIL reset_din got=%h want=0", pmem_din); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    int idx;
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = (c == 0);
      ofifo_valid = (c >= 1);
      ofifo_out = row_val(idx + 500, 0);
      #1;
      if (ofifo_rd) idx++;
      if (idx == 5) break;
    end
    total_cnt++;
    if (idx != 5) begin bad_cnt++; $display("FAIL mid_pops got=%0d want=5", idx); end
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({ofifo_rd, pmem_wr, pmem_rd, acc, sfp_clr, sfp_valid, busy, done, pmem_addr, pmem_din} !== '0) begin
      bad_cnt++;
      $display("FAIL mid_reset_outs got busy=%b wr=%b addr=%0d din=%h want all 0",
               busy, pmem_wr, pmem_addr, pmem_din);
    end
    @(negedge clk);
    reset = 1'b1;
    run(0, 0, -1);
    total_cnt++;
    if (first_wr_addr != 0) begin bad_cnt++; $display("FAIL redrain_first_addr got=%0d want=0", first_wr_addr); end
    total_cnt++;
    if (wr_cnt != TOT) begin bad_cnt++; $display("FAIL redrain_writes got=%0d want=%0d", wr_cnt, TOT); end
    total_cnt++;
    if (wr_data_bad != 0) begin bad_cnt++; $display("FAIL redrain_data got=%0d bad want=0", wr_data_bad); end
  endtask

  task automatic test_stream();
    run(0, 0, -1);
    total_cnt++;
    if (done_cnt != 1) begin bad_cnt++; $display("FAIL stream_done got=%0d want=1", done_cnt); end
    total_cnt++;
    if (wr_cnt != TOT) begin bad_cnt++; $display("FAIL stream_writes got=%0d want=%0d", wr_cnt, TOT); end
    total_cnt++;
    if (wr_addr_bad != 0) begin bad_cnt++; $display("FAIL stream_addr got=%0d bad want=0", wr_addr_bad); end
    total_cnt++;
    if (wr_data_bad != 0) begin bad_cnt++; $display("FAIL stream_data got=%0d bad want=0", wr_data_bad); end
    total_cnt++;
    if (done_cyc != 307) begin bad_cnt++; $display("FAIL stream_done_cycle got=%0d want=307", done_cyc); end
    for (int o = 0; o < NO; o++) begin
      total_cnt++;
      if (o >= sums.size() || sums[o] != 576 + 9 * o) begin
        bad_cnt++;
        $display("FAIL stream_sum%0d got=%0d want=%0d", o, (o < sums.size()) ? sums[o] : -1, 576 + 9 * o);
      end
    end
    total_cnt++;
    if (viol != 0) begin bad_cnt++; $display("FAIL stream_invariants got=%0d want=0", viol); end
  endtask

  task automatic test_ofifo_gaps();
    run(1, 0, -1);
    total_cnt++;
    if (follow_bad != 0) begin bad_cnt++; $display("FAIL gaps_rd_follow got=%0d want=0", follow_bad); end
    total_cnt++;
    if (wr_cnt != TOT) begin bad_cnt++; $display("FAIL gaps_writes got=%0d want=%0d", wr_cnt, TOT); end
    total_cnt++;
    if (wr_addr_bad != 0) begin bad_cnt++; $display("FAIL gaps_addr got=%0d bad want=0", wr_addr_bad); end
    total_cnt++;
    if (wr_data_bad != 0) begin bad_cnt++; $display("FAIL gaps_data got=%0d bad want=0", wr_data_bad); end
    total_cnt++;
    if (viol != 0) begin bad_cnt++; $display("FAIL gaps_invariants got=%0d want=0", viol); end
  endtask

  task automatic test_accum();
    int nbad;
    run(0, 1, -1);
    total_cnt++;
    if (sfp_cnt != NO) begin bad_cnt++; $display("FAIL accum_sfp_count got=%0d want=%0d", sfp_cnt, NO); end
    total_cnt++;
    if (sfp_time_bad != 0) begin bad_cnt++; $display("FAIL accum_sfp_timing got=%0d want=0", sfp_time_bad); end
    total_cnt++;
    if (rd_cnt != TOT) begin bad_cnt++; $display("FAIL accum_reads got=%0d want=%0d", rd_cnt, TOT); end
    total_cnt++;
    if (rd_addr_bad != 0) begin bad_cnt++; $display("FAIL accum_rd_addr got=%0d want=0", rd_addr_bad); end
    total_cnt++;
    if (rd_time_bad != 0) begin bad_cnt++; $display("FAIL accum_rd_spacing got=%0d want=0", rd_time_bad); end
    total_cnt++;
    if (clr_bad != 0) begin bad_cnt++; $display("FAIL accum_sfp_clr got=%0d want=0", clr_bad); end
    nbad = 0;
    foreach (sums[i]) if (sums[i] != 45) nbad++;
    total_cnt++;
    if (nbad != 0 || sums.size() != NO) begin
      bad_cnt++;
      $display("FAIL accum_sums got=%0d wrong of %0d want 0 of %0d", nbad, sums.size(), NO);
    end
    total_cnt++;
    if (viol != 0) begin bad_cnt++; $display("FAIL accum_invariants got=%0d want=0", viol); end
  endtask

  task automatic test_start_ignored();
    run(0, 1, 200);
    total_cnt++;
    if (done_cnt != 1) begin bad_cnt++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
    total_cnt++;
    if (busy_bad != 0) begin bad_cnt++; $display("FAIL ignore_busy_at_done got=%0d want=0", busy_bad); end
    total_cnt++;
    if (done_cyc != 307) begin bad_cnt++; $display("FAIL ignore_done_cycle got=%0d want=307", done_cyc); end
    total_cnt++;
    if (busy !== 1'b0) begin bad_cnt++; $display("FAIL ignore_idle_busy got=%b want=0", busy); end
    total_cnt++;
    if (viol != 0) begin bad_cnt++; $display("FAIL ignore_invariants got=%0d want=0", viol); end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt = 0;
    test_reset();
    test_reset_mid_drain();
    test_stream();
    test_ofifo_gaps();
    test_accum();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
